// File: rtl/sar_search_4.sv
// sar_search_4: 4-bit binary search driven by an external magnitude comparator.
// Ports: clk, reset (async high), start, cmp_gt/eq/lt in; probe, busy, done,
//        result, found, err out. probe feeds the comparator's B operand.
module sar_search_4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cmp_gt,
    input  logic       cmp_eq,
    input  logic       cmp_lt,
    output logic [3:0] probe,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       found,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] lo_q, lo_d;
    logic [4:0] hi_q, hi_d;
    logic [3:0] probe_q, probe_d;
    logic [3:0] result_q, result_d;
    logic       found_q, found_d;
    logic       err_q, err_d;

    // Candidate bounds; 5 bits so lo can pass hi without wrapping.
    logic [4:0] lo_up;
    logic [4:0] hi_dn;

    assign lo_up = {1'b0, probe_q} + 5'd1;
    assign hi_dn = {1'b0, probe_q} - 5'd1;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d     = 5'd0;
                    hi_d     = 5'd15;
                    probe_d  = 4'd7;
                    result_d = 4'd0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_SEARCH;
                end
            end
            S_SEARCH: begin
                case ({cmp_gt, cmp_eq, cmp_lt})
                    3'b010: begin
                        result_d = probe_q;
                        found_d  = 1'b1;
                        state_d  = S_DONE;
                    end
                    3'b100: begin
                        // probe 15 has no upper neighbour to move to.
                        if (probe_q == 4'd15 || lo_up > hi_q) begin
                            result_d = probe_q;
                            state_d  = S_DONE;
                        end else begin
                            lo_d    = lo_up;
                            probe_d = 4'((lo_up + hi_q) >> 1);
                        end
                    end
                    3'b001: begin
                        // hi_dn wraps at probe 0; caught before use.
                        if (probe_q == 4'd0 || lo_q > hi_dn) begin
                            result_d = probe_q;
                            state_d  = S_DONE;
                        end else begin
                            hi_d    = hi_dn;
                            probe_d = 4'((lo_q + hi_dn) >> 1);
                        end
                    end
                    default: begin
                        // None or several flags: comparator is inconsistent.
                        result_d = probe_q;
                        found_d  = 1'b0;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lo_q     <= 5'd0;
            hi_q     <= 5'd15;
            probe_q  <= 4'd0;
            result_q <= 4'd0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign probe  = probe_q;
    assign busy   = (state_q == S_SEARCH);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign found  = found_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search_4.sv
// tb_sar_search_4: scoreboard bench for sar_search_4 with a behavioural
// comparator; target held doubled (t2) so half-integer targets are possible.
module tb_sar_search_4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cmp_gt, cmp_eq, cmp_lt;
    logic [3:0] probe, result;
    logic       busy, done, found, err;

    int         t2;
    logic       ovr;
    logic [2:0] ovr_f;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] res;
        logic       fnd;
        logic       er;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    int   pq[$];
    int   obs_p[$];
    int   obs_lat;
    logic [3:0] obs_res;
    logic obs_fnd, obs_err;

    sar_search_4 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (ovr) begin
            {cmp_gt, cmp_eq, cmp_lt} = ovr_f;
        end else begin
            cmp_gt = (t2 > 2 * int'(probe));
            cmp_eq = (t2 == 2 * int'(probe));
            cmp_lt = (t2 < 2 * int'(probe));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference binary search over doubled target.
    function automatic void model(input int tt, output logic [23:0] seq,
                                  output int n, output logic [3:0] r,
                                  output logic f);
        int lo, hi, p;
        lo = 0; hi = 15; seq = '0; n = 0; r = '0; f = 1'b0;
        for (int k = 0; k < 6; k++) begin
            p = (lo + hi) / 2;
            seq[4*n +: 4] = p[3:0];
            n++;
            r = p[3:0];
            if (2 * p == tt) begin
                f = 1'b1;
                break;
            end
            if (tt > 2 * p) begin
                if (p == 15) break;
                lo = p + 1;
            end else begin
                if (p == 0) break;
                hi = p - 1;
            end
            if (lo > hi) break;
        end
    endfunction

    // Caller is at a negedge; start is raised now, sampled next posedge.
    task automatic launch(input int tt, input bit hold);
        t2 = tt;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        obs_p.delete();
        obs_lat = 1;
        while (!done && obs_lat < 20) begin
            if (busy) obs_p.push_back(int'(probe));
            @(negedge clk);
            obs_lat++;
        end
        obs_res = result;
        obs_fnd = found;
        obs_err = err;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; t2 = 0; ovr = 1'b0; ovr_f = 3'b000;
        #12;
        n_chk++;
        if ({probe, busy, done, result, found, err} !== 12'd0)
            $display("FAIL reset_outs: got %h want 000", {probe, busy, done, result, found, err});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_search(input string nm, input int tt,
                               input logic [3:0] er, input logic ef,
                               input logic ee, input int el,
                               input logic [23:0] seq, input int n);
        exp_t e;
        int   want, got;
        e.res = er; e.fnd = ef; e.er = ee; e.lat = el;
        sbq.push_back(e);
        for (int i = 0; i < n; i++) pq.push_back(int'(seq[4*i +: 4]));
        launch(tt, 1'b0);
        e = sbq.pop_front();
        n_chk++;
        if (done !== 1'b1 || obs_lat != e.lat)
            $display("FAIL %s latency: got %0d (done=%b) want %0d", nm, obs_lat, done, e.lat);
        else n_pass++;
        n_chk++;
        if ({obs_res, obs_fnd, obs_err} !== {e.res, e.fnd, e.er})
            $display("FAIL %s outcome: got r=%0d f=%b e=%b want r=%0d f=%b e=%b",
                     nm, obs_res, obs_fnd, obs_err, e.res, e.fnd, e.er);
        else n_pass++;
        n_chk++;
        if (obs_p.size() != pq.size())
            $display("FAIL %s probe_count: got %0d want %0d", nm, obs_p.size(), pq.size());
        else n_pass++;
        for (int i = 0; pq.size() > 0; i++) begin
            want = pq.pop_front();
            got = (obs_p.size() > 0) ? obs_p.pop_front() : -1;
            n_chk++;
            if (got != want)
                $display("FAIL %s probe[%0d]: got %0d want %0d", nm, i, got, want);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++;
        if ({done, busy, result, found, err} !== {2'b00, e.res, e.fnd, e.er})
            $display("FAIL %s after_done: got d=%b b=%b r=%0d f=%b e=%b want idle+hold",
                     nm, done, busy, result, found, err);
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [23:0] seq;
        int          n;
        logic [3:0]  r;
        logic        f;
        for (int tt = -2; tt <= 32; tt++) begin
            model(tt, seq, n, r, f);
            test_search($sformatf("sweep_t2_%0d", tt), tt, r, f, 1'b0, n + 1, seq, n);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] pats [3];
        exp_t e;
        pats[0] = 3'b000; pats[1] = 3'b101; pats[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            e.res = 4'd7; e.fnd = 1'b0; e.er = 1'b1; e.lat = 2;
            sbq.push_back(e);
            t2 = 14;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            ovr = 1'b1;
            ovr_f = pats[i];
            n_chk++;
            if (busy !== 1'b1 || probe !== 4'd7)
                $display("FAIL illegal%0d first_search: got b=%b p=%0d want b=1 p=7", i, busy, probe);
            else n_pass++;
            @(negedge clk);
            ovr = 1'b0;
            e = sbq.pop_front();
            n_chk++;
            if ({done, busy, result, found, err} !== {2'b10, e.res, e.fnd, e.er})
                $display("FAIL illegal%0d flags=%b: got d=%b b=%b r=%0d f=%b e=%b want d=1 r=7 f=0 e=1",
                         i, pats[i], done, busy, result, found, err);
            else n_pass++;
            @(negedge clk);
            n_chk++;
            if (done !== 1'b0 || err !== 1'b1)
                $display("FAIL illegal%0d hold: got d=%b e=%b want d=0 e=1", i, done, err);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        int c;
        t2 = 30;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (probe !== 4'd13 && c < 10) begin
            @(negedge clk);
            c++;
        end
        n_chk++;
        if (probe !== 4'd13 || busy !== 1'b1)
            $display("FAIL midrst reach13: got p=%0d b=%b want p=13 b=1", probe, busy);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_chk++;
        if ({probe, busy, done, result, found, err} !== 12'd0)
            $display("FAIL midrst async: got %h want 000", {probe, busy, done, result, found, err});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        test_search("rst_t9", 18, 4'd9, 1'b1, 1'b0, 4, 24'h0009b7, 3);
    endtask

    task automatic test_restart_ignored();
        exp_t e;
        int   n_done;
        logic [3:0] r_at;
        e.res = 4'd12; e.fnd = 1'b1; e.er = 1'b0; e.lat = 5;
        sbq.push_back(e);
        t2 = 24;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        r_at = 4'd0;
        for (int c = 1; c <= 14; c++) begin
            start = (c == 2);
            if (done) begin
                n_done++;
                r_at = result;
            end
            @(negedge clk);
        end
        start = 1'b0;
        e = sbq.pop_front();
        n_chk++;
        if (n_done != 1 || r_at !== e.res)
            $display("FAIL restart_ignored: got dones=%0d r=%0d want 1 r=%0d", n_done, r_at, e.res);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0 || found !== 1'b1)
            $display("FAIL restart_ignored idle: got b=%b f=%b want b=0 f=1", busy, found);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   c;
        e.res = 4'd5; e.fnd = 1'b1; e.er = 1'b0; e.lat = 4;
        sbq.push_back(e);
        sbq.push_back(e);
        launch(10, 1'b1);
        e = sbq.pop_front();
        n_chk++;
        if (done !== 1'b1 || obs_lat != e.lat || obs_res !== e.res)
            $display("FAIL b2b first: got lat=%0d r=%0d d=%b want lat=%0d r=%0d",
                     obs_lat, obs_res, done, e.lat, e.res);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b idle_gap: got b=%b d=%b want 0 0", busy, done);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || probe !== 4'd7 || found !== 1'b0)
            $display("FAIL b2b restart: got b=%b p=%0d f=%b want b=1 p=7 f=0", busy, probe, found);
        else n_pass++;
        start = 1'b0;
        c = 0;
        while (!done && c < 20) begin
            @(negedge clk);
            c++;
        end
        e = sbq.pop_front();
        n_chk++;
        if (done !== 1'b1 || result !== e.res || found !== e.fnd)
            $display("FAIL b2b second: got d=%b r=%0d f=%b want d=1 r=%0d f=1",
                     done, result, found, e.res);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_search("t7", 14, 4'd7, 1'b1, 1'b0, 2, 24'h000007, 1);
        test_search("t15", 30, 4'd15, 1'b1, 1'b0, 6, 24'h0fedb7, 5);
        test_search("t0", 0, 4'd0, 1'b1, 1'b0, 5, 24'h000137, 4);
        test_search("nf_top", 32, 4'd15, 1'b0, 1'b0, 6, 24'h0fedb7, 5);
        test_search("nf_bot", -2, 4'd0, 1'b0, 1'b0, 5, 24'h000137, 4);
        test_search("nf_cross", 15, 4'd8, 1'b0, 1'b0, 5, 24'h0089b7, 4);
        test_illegal();
        test_mid_reset();
        test_restart_ignored();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sar_search_4.md
SAR_SEARCH_4 -- requirements
Module: sar_search_4

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, and one reset, `reset`; `reset` SHALL be asynchronous and active-high.
REQ-002 The block SHALL expose these ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  async active-high reset.
- `start`  in  1  request a new search; sampled in IDLE only.
- `cmp_gt`  in  1  external 4-bit comparator: target > probe.
- `cmp_eq`  in  1  external comparator: target == probe.
- `cmp_lt`  in  1  external comparator: target < probe.
- `probe`  out  4  value driven to the comparator's B input.
- `busy`  out  1  high in SEARCH.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  4  located value; valid from the done cycle.
- `found`  out  1  search ended on `cmp_eq`.
- `err`  out  1  search ended on an illegal flag combination.
REQ-003 The block SHALL have no parameters; all widths are fixed at 4 bits.

Function
REQ-004 The block SHALL act as the consumer of a 4-bit magnitude comparator's three-flag output, performing a binary search for the comparator's hidden A operand.
REQ-005 The block SHALL implement exactly three states: IDLE, SEARCH and DONE.
REQ-006 In IDLE with `start`=1 at a clock edge, the block SHALL set lo=0 and hi=15 (both 5-bit), set `probe`=7, clear `result`/`found`/`err`, and enter SEARCH.
REQ-007 In SEARCH, `probe` SHALL equal floor((lo+hi)/2), computed on a 5-bit sum and registered, so `probe` is stable for the whole cycle in which the flags are sampled.
REQ-008 At each SEARCH clock edge the block SHALL sample the flags and act as follows:
- eq only: `result`<=`probe`, `found`<=1, go to DONE.
- gt only: lo<=`probe`+1, new `probe` from the updated bounds.
- lt only: hi<=`probe`-1, new `probe` from the updated bounds.
REQ-009 The block SHALL end the search with `found`=0, `err`=0, `result`=`probe` and go to DONE on any of these not-found conditions:
- gt only with `probe`=15.
- lt only with `probe`=0.
- updated lo > updated hi.
REQ-010 If the flags in a SEARCH cycle are not exactly one-hot (none high, or two or more high), the block SHALL set `err`=1 and `found`=0, set `result`=`probe`, and go to DONE.
REQ-011 DONE SHALL last exactly one cycle: `done`=1 and `busy`=0, then IDLE unconditionally.
REQ-012 `result`, `found` and `err` SHALL hold their values through IDLE until the next accepted `start`; `probe` SHALL hold its last value in IDLE and DONE.
REQ-013 `start` during SEARCH or DONE SHALL be ignored, with no restart and no queuing.
REQ-014 `start` held high continuously SHALL begin a new search on the first IDLE edge after DONE.
REQ-015 With a consistent comparator, a search SHALL take at most 5 SEARCH cycles.
REQ-016 Latency SHALL be exactly k+1 cycles from the start-accepting edge to `done`, where k is the number of SEARCH cycles.

Reset
REQ-017 On `reset`=1, in any state including mid-search, the block SHALL immediately enter IDLE and drive all outputs to 0, with lo=0 and hi=15.
REQ-018 Release of `reset` SHALL require no extra cycles; `start` on the first edge after release SHALL be accepted.

Verification
REQ-019 The bench SHALL model the comparator combinationally from a target register T and `probe`, and SHALL cover these directed scenarios:
- T=7, pulse `start`: probe sequence 7; `done` on cycle 2; `result`=7, `found`=1, `err`=0.
- T=15: probe sequence 7,11,13,14,15; `done` on cycle 6; `result`=15, `found`=1.
- T=0: probe sequence 7,3,1,0; `done` on cycle 5; `result`=0, `found`=1.
- Force all flags low on the first SEARCH cycle: next cycle `done`=1, `err`=1, `found`=0, `result`=7; repeat with gt and lt both high and expect the same.
- T=15, assert `reset` while `probe`=13: all outputs 0 at once; after release, `start` with T=9 gives probes 7,11,9, `result`=9.
- Pulse `start` again during SEARCH (T=12): it is ignored; exactly one `done` pulse with `result`=12; `start` held high gives back-to-back searches separated by exactly one IDLE cycle.
